// File: rtl/vector_pkg.sv
// Shared constants and types for the vector memory read path.
package vector_pkg;

    localparam int LANES  = 16;
    localparam int LANE_W = 8;
    localparam int MEM_W  = 32;
    localparam int BEATS  = LANES * LANE_W / MEM_W;

    typedef logic [LANE_W-1:0] lane_t;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        DONE
    } vec_rd_state_t;

endpackage

// File: rtl/vector_beat_assembler.sv
// Beat counter and staging register: places each accepted beat into its slot of the vector,
// beat 0 landing in the most significant bits.
module vector_beat_assembler #(
    parameter int LANES  = vector_pkg::LANES,
    parameter int LANE_W = vector_pkg::LANE_W,
    parameter int MEM_W  = vector_pkg::MEM_W
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clear,
    input  logic                    beat_valid,
    input  logic [MEM_W-1:0]        beat_data,
    output logic                    last_beat,
    output logic [LANES*LANE_W-1:0] assembled
);

    localparam int VEC_W  = LANES * LANE_W;
    localparam int BEATS  = VEC_W / MEM_W;
    localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

    logic [BEAT_W-1:0] beat;
    logic [VEC_W-1:0]  staging;

    assign last_beat = (beat == BEAT_W'(BEATS - 1));

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        assembled = staging;
        assembled[VEC_W-1 - int'(beat)*MEM_W -: MEM_W] = beat_data;
    end

    // NOTE: the staging register is reset so an aborted read never leaves stale data observable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat    <= '0;
            staging <= '0;
        end else if (clear) begin
            beat <= '0;
        end else if (beat_valid) begin
            staging <= assembled;
            beat    <= last_beat ? '0 : beat + BEAT_W'(1);
        end
    end

endmodule

// File: rtl/vector_memory_reader.sv
// Fetches one vector from data memory in MEM_W-bit beats and presents it as byte lanes.
// Optional feature macro: VECTOR_READER_TIMEOUT_EN (per-beat wait timeout, adds timeout_err).
module vector_memory_reader
    import vector_pkg::*;
#(
    parameter int LANES          = vector_pkg::LANES,
    parameter int LANE_W         = vector_pkg::LANE_W,
    parameter int ADDR_W         = 12,
    parameter int MEM_W          = vector_pkg::MEM_W,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                start,
    input  logic [ADDR_W-1:0]                   memory_base,
    output logic                                busy,
    output logic                                done,
    output logic                                mem_req,
    output logic [ADDR_W-1:0]                   mem_address,
    input  logic                                mem_ready,
    input  logic [MEM_W-1:0]                    mem_rdata,
`ifdef VECTOR_READER_TIMEOUT_EN
    output logic                                timeout_err,
`endif
    output logic [LANES*LANE_W-1:0]             vector_data_out,
    output logic [0:LANES-1][LANE_W-1:0]        vector_lanes_out
);

    localparam int VEC_W = LANES * LANE_W;
    localparam int OFS_W = $clog2(MEM_W / 8);

    vec_rd_state_t    state, next_state;
    logic             launch, accept, last_beat, timeout_hit;
    logic [VEC_W-1:0] assembled;

    assign launch = (state != REQ) && start;
    assign accept = (state == REQ) && mem_ready;

    vector_beat_assembler #(
        .LANES (LANES),
        .LANE_W(LANE_W),
        .MEM_W (MEM_W)
    ) u_assembler (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (launch),
        .beat_valid(accept),
        .beat_data (mem_rdata),
        .last_beat (last_beat),
        .assembled (assembled)
    );

`ifdef VECTOR_READER_TIMEOUT_EN
    localparam int WAIT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [WAIT_W-1:0] wait_cnt;

    assign timeout_hit = (state == REQ) && !mem_ready && (wait_cnt == WAIT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt    <= '0;
            timeout_err <= 1'b0;
        end else begin
            timeout_err <= timeout_hit;
            if (launch || accept || timeout_hit) begin
                wait_cnt <= '0;
            end else if (state == REQ) begin
                wait_cnt <= wait_cnt + WAIT_W'(1);
            end
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    always_comb begin
        next_state = state;
        unique case (state)
            IDLE:    if (start) next_state = REQ;
            REQ: begin
                if (accept && last_beat) next_state = DONE;
                else if (timeout_hit)    next_state = IDLE;
            end
            DONE:    next_state = start ? REQ : IDLE;
            default: next_state = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= IDLE;
            mem_address     <= '0;
            vector_data_out <= '0;
        end else begin
            state <= next_state;
            if (launch) begin
                mem_address <= {memory_base[ADDR_W-1:OFS_W], OFS_W'(0)};
            end else if (accept && !last_beat) begin
                mem_address <= mem_address + ADDR_W'(MEM_W / 8);
            end
            if (accept && last_beat) begin
                vector_data_out <= assembled;
            end
        end
    end

    assign busy             = (state == REQ);
    assign mem_req          = (state == REQ);
    assign done             = (state == DONE);
    assign vector_lanes_out = vector_data_out;

endmodule
